// File: rtl/filter_compare_sequencer.sv
// Sequences each sample through the filter then compare engine with a per-stage watchdog.
// Latency: start pulses and results one cycle after the triggering edge; no new sample is taken while busy or in ERROR.
module filter_compare_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_ready,
  output logic             data_ack,
  output logic             filter_start,
  input  logic             filter_done,
  output logic             compare_start,
  input  logic             compare_done,
  input  logic             compare_match,
  output logic             busy,
  output logic             result_valid,
  output logic             result_match,
  output logic [CNT_W-1:0] match_count,
  output logic             err_timeout,
  output logic             err_stage,
  input  logic             clear_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILT_WAIT = 2'd1,
    CMP_WAIT  = 2'd2,
    ERROR     = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             data_ack_nxt;
  logic             filter_start_nxt;
  logic             compare_start_nxt;
  logic             result_valid_nxt;
  logic             result_match_nxt;
  logic [CNT_W-1:0] match_count_nxt;
  logic             err_stage_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      data_ack      <= 1'b0;
      filter_start  <= 1'b0;
      compare_start <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_match  <= 1'b0;
      match_count   <= '0;
      err_timeout   <= 1'b0;
      err_stage     <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      data_ack      <= data_ack_nxt;
      filter_start  <= filter_start_nxt;
      compare_start <= compare_start_nxt;
      busy          <= (state_nxt != IDLE);
      result_valid  <= result_valid_nxt;
      result_match  <= result_match_nxt;
      match_count   <= match_count_nxt;
      err_timeout   <= (state_nxt == ERROR);
      err_stage     <= err_stage_nxt;
    end
  end

  // A done seen on the timeout edge takes priority over the watchdog.
  always_comb begin
    state_nxt         = state;
    timer_nxt         = timer;
    data_ack_nxt      = 1'b0;
    filter_start_nxt  = 1'b0;
    compare_start_nxt = 1'b0;
    result_valid_nxt  = 1'b0;
    result_match_nxt  = result_match;
    match_count_nxt   = match_count;
    err_stage_nxt     = err_stage;
    case (state)
      IDLE: begin
        if (data_ready) begin
          state_nxt        = FILT_WAIT;
          data_ack_nxt     = 1'b1;
          filter_start_nxt = 1'b1;
          timer_nxt        = '0;
        end
      end
      FILT_WAIT: begin
        if (filter_done) begin
          state_nxt         = CMP_WAIT;
          compare_start_nxt = 1'b1;
          timer_nxt         = '0;
        end else if (timer == TMR_LAST) begin
          state_nxt     = ERROR;
          err_stage_nxt = 1'b0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      CMP_WAIT: begin
        if (compare_done) begin
          state_nxt        = IDLE;
          result_valid_nxt = 1'b1;
          result_match_nxt = compare_match;
          if (compare_match && (match_count != CNT_MAX)) begin
            match_count_nxt = match_count + 1'b1;
          end
        end else if (timer == TMR_LAST) begin
          state_nxt     = ERROR;
          err_stage_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ERROR: begin
        if (clear_err) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
